din_stream_fifo: RTL and testbench

//  Elastic byte-stream FIFO directly upstream of the din consumer stage.

---
 rtl/din_stream_pkg.sv | 5 +
 rtl/din_stream_mem.sv | 18 +
 rtl/din_stream_fifo.sv | 67 ++++++
 tb/tb_din_stream_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/din_stream_pkg.sv
// din_stream_pkg: shared width and byte type for the din stream path
package din_stream_pkg;
    localparam int DIN_DW = 8;
    typedef logic [DIN_DW-1:0] din_byte_t;
endpackage

// File: rtl/din_stream_mem.sv
// din_stream_mem: DEPTH x DW storage, one write port, async read, no reset
module din_stream_mem #(
    parameter int DW = 8,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/din_stream_fifo.sv
// din_stream_fifo: first-word-fall-through elastic FIFO feeding consumer din,
// with fill level and a sticky flag for producers that withdraw stalled data
module din_stream_fifo
    import din_stream_pkg::*;
#(
    parameter int DW = DIN_DW,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          flush,
    output logic [AW:0]   count,
    output logic          proto_err
);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr, count_q;
    logic ready_en, stall_q, err_q, push, pop, ptr_msb_unused;
    logic [DW-1:0] rdata;
    assign in_ready = ready_en & (count_q != FULL);
    assign out_valid = count_q != '0;
    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    assign out_data = out_valid ? rdata : '0;
    assign count = count_q;
    assign proto_err = err_q;
    assign ptr_msb_unused = wr_ptr[AW] ^ rd_ptr[AW];
    // ready_en keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count_q <= '0;
            ready_en <= 1'b0;
            stall_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            stall_q <= in_valid & ~in_ready;
            err_q <= err_q | (stall_q & ~in_valid);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count_q <= '0;
            end else begin
                wr_ptr <= push ? wr_ptr + ONE : wr_ptr;
                rd_ptr <= pop ? rd_ptr + ONE : rd_ptr;
                count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    din_stream_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(push & ~flush),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(in_data),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_din_stream_fifo.sv
// tb_din_stream_fifo: vector table, corner sequences and queue-model random run
module tb_din_stream_fifo;
    import din_stream_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic in_ready, out_valid, proto_err;
    din_byte_t in_data = '0, out_data;
    logic [2:0] count;
    int checks = 0, failures = 0;
    typedef struct packed {
        logic iv; logic [7:0] d; logic ordy;
        logic [2:0] cnt; logic ov; logic [7:0] od; logic ir;
    } vec_t;
    vec_t vec [11];
    din_byte_t q [$];
    logic stall_m, err_m;
    always #5 clk = ~clk;
    din_stream_fifo #(.DW(DIN_DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count), .proto_err(proto_err)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic cycle(input logic iv, input din_byte_t d, input logic ordy, input logic fl);
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
    endtask
    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask
    initial begin
        vec[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1};
        vec[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'h11, 1'b1};
        vec[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1};
        vec[3]  = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0};
        vec[4]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0};
        vec[5]  = '{1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 8'h22, 1'b1};
        vec[6]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 8'h22, 1'b0};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h33, 1'b1};
        vec[8]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h44, 1'b1};
        vec[9]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h55, 1'b1};
        vec[10] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1};
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        rst = 1'b0;
        #1 check("release_in_ready_low", 32'(in_ready), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("release_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 11; i++) begin
            cycle(vec[i].iv, vec[i].d, vec[i].ordy, 1'b0);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(vec[i].cnt));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ov));
            check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(vec[i].od));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vec[i].ir));
            check($sformatf("tbl%0d_proto_err", i), 32'(proto_err), 0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, din_byte_t'(i), 1'b1, 1'b0);
            check($sformatf("stream%0d_count", i), 32'(count), 1);
            check($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_drain", 32'(count), 0);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        check("flush_pre_count", 32'(count), 2);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        check("flush_count", 32'(count), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        check("flush_next_count", 32'(count), 1);
        check("flush_next_data", 32'(out_data), 32'h00BB);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, din_byte_t'(8'h60 + i), 1'b0, 1'b0);
        check("err_full_in_ready", 32'(in_ready), 0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check("err_before_drop", 32'(proto_err), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("err_after_drop", 32'(proto_err), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("err_after_flush", 32'(proto_err), 1);
        check("err_flush_count", 32'(count), 0);
        do_reset();
        check("err_after_rst", 32'(proto_err), 0);
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        check("async_pre_count", 32'(count), 2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_count", 32'(count), 0);
        check("async_in_ready", 32'(in_ready), 0);
        check("async_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("async_release_in_ready", 32'(in_ready), 1);
        q.delete();
        stall_m = 1'b0;
        err_m = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic iv, ordy, fl, full_m, push_m, pop_m;
            din_byte_t d;
            iv = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 99) < (n < 200 ? 30 : 70);
            fl = $urandom_range(0, 39) == 0;
            d = din_byte_t'($urandom);
            full_m = q.size() == DEPTH;
            push_m = iv && !full_m;
            pop_m = ordy && q.size() != 0;
            cycle(iv, d, ordy, fl);
            err_m = err_m | (stall_m & ~iv);
            stall_m = iv & full_m;
            if (fl) q.delete();
            else begin
                if (pop_m) void'(q.pop_front());
                if (push_m) q.push_back(d);
            end
            check($sformatf("rand%0d", n),
                  32'({count, out_valid, out_data, in_ready, proto_err}),
                  32'({3'(q.size()), q.size() != 0, q.size() != 0 ? q[0] : 8'h00,
                       q.size() != DEPTH, err_m}));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
